// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, sample-pair type and slot decode helpers.
// Used by i2s_tx and by the capture decoder so both agree on slot timing.
package i2s_pkg;

  localparam int FRAME_BITS     = 64;
  localparam int SLOT_BITS      = 32;
  localparam int LEFT_FIRST     = 1;
  localparam int RIGHT_FIRST    = 33;
  localparam int DEFAULT_DATA_W = 24;

  localparam int SLOT_CNT_W = $clog2(FRAME_BITS);
  localparam int WS_BIT     = $clog2(SLOT_BITS);

  typedef logic [SLOT_CNT_W-1:0] slot_t;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] left;
    logic [DEFAULT_DATA_W-1:0] right;
  } i2s_pair_t;

  // True when slot k carries a data bit of the left word of width dw.
  function automatic logic in_left_slot(input slot_t k, input int dw);
    return (int'(k) >= LEFT_FIRST) && (int'(k) < LEFT_FIRST + dw);
  endfunction

  function automatic logic in_right_slot(input slot_t k, input int dw);
    return (int'(k) >= RIGHT_FIRST) && (int'(k) < RIGHT_FIRST + dw);
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair valid/ready handshake between a producer (master) and i2s_tx (slave).
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] left_in;
  logic [DATA_W-1:0] right_in;

  modport master (
    output sample_valid,
    output left_in,
    output right_in,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  left_in,
    input  right_in,
    output sample_ready
  );

endinterface

// File: rtl/i2s_clkgen.sv
// SCK/WS generator: divides clk into SCK, counts 64 slots per frame and
// flags the rise, fall and frame-start events one cycle before SCK changes.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int HALF_DIV = 8
) (
  input  logic  clk,
  input  logic  reset,
  output logic  sck_o,
  output logic  ws_o,
  output logic  rise_o,
  output logic  fall_o,
  output slot_t bit_cnt_o,
  output logic  frame_start_o
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  slot_t            bit_cnt_q, bit_cnt_d;
  logic             wrap;

  // The event strobes are decoded from the current state, so a consumer acting
  // on them updates its registers on the same edge that SCK toggles.
  always_comb begin
    wrap      = (div_cnt_q == DIV_W'(HALF_DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    sck_d     = wrap ? ~sck_q : sck_q;
    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    if (wrap && sck_q) begin
      bit_cnt_d = bit_cnt_q + slot_t'(1);
      ws_d      = bit_cnt_d[WS_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign rise_o        = wrap && !sck_q;
  assign fall_o        = wrap && sck_q;
  assign frame_start_o = fall_o && (bit_cnt_q == slot_t'(FRAME_BITS - 1));
  assign sck_o         = sck_q;
  assign ws_o          = ws_q;
  assign bit_cnt_o     = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one holding register behind a valid/ready port, loaded
// into left/right shifters at each frame start. Optional I2S_TX_HOLD_LAST_EN repeats
// the last pair on underrun instead of sending zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int HALF_DIV = 8
) (
  input  logic     clk,
  input  logic     reset,
  i2s_tx_if.slave  smp,
  output logic     SCK,
  output logic     WS,
  output logic     SD,
  output logic     underrun
);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  logic  rise, fall, frame_start;
  slot_t bit_cnt;

  pair_t             hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] sh_l_q, sh_l_d;
  logic [DATA_W-1:0] sh_r_q, sh_r_d;
  logic              sd_q, sd_d;
  logic              underrun_q, underrun_d;
`ifdef I2S_TX_HOLD_LAST_EN
  pair_t             last_q, last_d;
`endif

  i2s_clkgen #(
    .HALF_DIV(HALF_DIV)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .sck_o        (SCK),
    .ws_o         (WS),
    .rise_o       (rise),
    .fall_o       (fall),
    .bit_cnt_o    (bit_cnt),
    .frame_start_o(frame_start)
  );

  // The frame load samples hold_full_q before any same-cycle transfer lands, so
  // a pair arriving on the load edge is counted as an underrun and waits a frame.
  // SD takes the shifter MSB on a rise; the shifter advances on the following
  // fall, after the receiver has sampled that bit.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    sd_d        = sd_q;
    underrun_d  = frame_start && !hold_full_q;
`ifdef I2S_TX_HOLD_LAST_EN
    last_d      = last_q;
`endif

    if (frame_start) begin
      if (hold_full_q) begin
        sh_l_d      = hold_q.left;
        sh_r_d      = hold_q.right;
        hold_full_d = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d      = hold_q;
`endif
      end else begin
`ifdef I2S_TX_HOLD_LAST_EN
        sh_l_d = last_q.left;
        sh_r_d = last_q.right;
`else
        sh_l_d = '0;
        sh_r_d = '0;
`endif
      end
    end else if (rise) begin
      if (in_left_slot(bit_cnt, DATA_W)) begin
        sd_d = sh_l_q[DATA_W-1];
      end else if (in_right_slot(bit_cnt, DATA_W)) begin
        sd_d = sh_r_q[DATA_W-1];
      end else begin
        sd_d = 1'b0;
      end
    end else if (fall) begin
      if (in_left_slot(bit_cnt, DATA_W)) begin
        sh_l_d = sh_l_q << 1;
      end else if (in_right_slot(bit_cnt, DATA_W)) begin
        sh_r_d = sh_r_q << 1;
      end
    end

    if (smp.sample_valid && !hold_full_q) begin
      hold_d.left  = smp.left_in;
      hold_d.right = smp.right_in;
      hold_full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
      last_q      <= '0;
`endif
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      sd_q        <= sd_d;
      underrun_q  <= underrun_d;
`ifdef I2S_TX_HOLD_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

  assign smp.sample_ready = !hold_full_q;
  assign SD               = sd_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a reference I2S sampler rebuilds each frame on SCK
// falls and compares it with the pair expected for that frame.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DW = 24;
  localparam int HD = 8;
  localparam int FRAME_CLKS = 128 * HD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCK, WS, SD, underrun;

  i2s_tx_if #(.DATA_W(DW)) bus ();

  i2s_tx #(
    .DATA_W  (DW),
    .HALF_DIV(HD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .smp     (bus),
    .SCK     (SCK),
    .WS      (WS),
    .SD      (SD),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  i2s_pair_t sb[$];

  // Edges since reset released; read on negedges.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic i2s_pair_t mkPair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    i2s_pair_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

  function automatic i2s_pair_t dPair(input int i);
    return mkPair(24'h800001 + 24'(i * 24'h010203), 24'h7FFFFE - 24'(i * 24'h030201));
  endfunction

  task automatic waitUntil(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyStimulus(input i2s_pair_t p, input int budget);
    int waited = 0;
    bus.sample_valid = 1'b1;
    bus.left_in      = p.left;
    bus.right_in     = p.right;
    while (bus.sample_ready !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("handshake_timeout", 32'(waited < budget), 32'd1);
    if (waited < budget) begin
      @(posedge clk);
      sb.push_back(p);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // Reference sampler: slot k is the one ending at this fall, counted from reset.
  logic      prevSck = 1'b0;
  int        falls = 0;
  logic [DW-1:0] curL = '0;
  logic [DW-1:0] curR = '0;
  always @(negedge clk) begin
    int k;
    i2s_pair_t exp;
    if (reset) begin
      prevSck = 1'b0;
      falls   = 0;
      curL    = '0;
      curR    = '0;
    end else begin
      if (prevSck === 1'b1 && SCK === 1'b0) begin
        k = falls % 64;
        falls++;
        checkOutput("ws_after_fall", 32'(WS), 32'((falls % 64) >= 32));
        if (k >= 1 && k <= 24)       curL = {curL[DW-2:0], SD};
        else if (k >= 33 && k <= 56) curR = {curR[DW-2:0], SD};
        else                         checkOutput("sd_idle_slot", 32'(SD), 32'd0);
        if (k == 63) begin
          checkOutput("sb_not_empty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("frame_left", 32'(curL), 32'(exp.left));
            checkOutput("frame_right", 32'(curR), 32'(exp.right));
          end
          curL = '0;
          curR = '0;
        end
      end
      prevSck = SCK;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int readyCnt;
    int idx;
    logic xfer;
    i2s_pair_t x, y, d;

    bus.sample_valid = 1'b0;
    bus.left_in      = '0;
    bus.right_in     = '0;

    // Reset values after 5 clks of reset.
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_sck", 32'(SCK), 32'd0);
    checkOutput("rst_ws", 32'(WS), 32'd0);
    checkOutput("rst_sd", 32'(SD), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_ready", 32'(bus.sample_ready), 32'd1);

    // Release and offer the first pair at once; frame 0 is all zeros.
    sb.push_back(mkPair('0, '0));
    reset = 1'b0;
    bus.sample_valid = 1'b1;
    bus.left_in      = 24'hABCDEF;
    bus.right_in     = 24'h123456;
    @(negedge clk);
    sb.push_back(mkPair(24'hABCDEF, 24'h123456));
    bus.sample_valid = 1'b0;
    checkOutput("ready_after_xfer", 32'(bus.sample_ready), 32'd0);

    while (SCK !== 1'b1 && cyc < 100) @(negedge clk);
    checkOutput("first_rise_cyc", 32'(cyc), 32'(HD));
    while (SCK !== 1'b0 && cyc < 100) @(negedge clk);
    checkOutput("first_fall_cyc", 32'(cyc), 32'(2 * HD));
    while (SCK !== 1'b1 && cyc < 100) @(negedge clk);
    checkOutput("second_rise_cyc", 32'(cyc), 32'(3 * HD));
    while (WS !== 1'b1 && cyc < 2000) @(negedge clk);
    checkOutput("ws_rise_cyc", 32'(cyc), 32'(64 * HD));

    waitUntil(FRAME_CLKS - 1);
    checkOutput("ready_before_load", 32'(bus.sample_ready), 32'd0);
    waitUntil(FRAME_CLKS);
    checkOutput("ws_fall_at_load", 32'(WS), 32'd0);
    checkOutput("ready_after_load", 32'(bus.sample_ready), 32'd1);
    checkOutput("no_underrun_full", 32'(underrun), 32'd0);

    // Back-pressure: valid held high with incrementing data for three frames.
    idx  = 0;
    xfer = 1'b0;
    readyCnt = 0;
    d = dPair(0);
    bus.sample_valid = 1'b1;
    bus.left_in      = d.left;
    bus.right_in     = d.right;
    for (int n = 0; n < 3 * FRAME_CLKS; n++) begin
      if (bus.sample_ready === 1'b1) begin
        readyCnt++;
        sb.push_back(dPair(idx));
        xfer = 1'b1;
      end
      @(negedge clk);
      if (xfer) begin
        idx++;
        d = dPair(idx);
        bus.left_in  = d.left;
        bus.right_in = d.right;
        xfer = 1'b0;
      end
    end
    bus.sample_valid = 1'b0;
    checkOutput("bp_ready_cycles", 32'(readyCnt), 32'd3);
    checkOutput("bp_underrun", 32'(underrun), 32'd0);

    // Frame 5 has no sample: underrun pulse and zeros (or a repeat of the last pair).
`ifdef I2S_TX_HOLD_LAST_EN
    sb.push_back(dPair(2));
`else
    sb.push_back(mkPair('0, '0));
`endif
    waitUntil(5 * FRAME_CLKS - 1);
    checkOutput("underrun_before", 32'(underrun), 32'd0);
    waitUntil(5 * FRAME_CLKS);
    checkOutput("underrun_pulse", 32'(underrun), 32'd1);
    waitUntil(5 * FRAME_CLKS + 1);
    checkOutput("underrun_after", 32'(underrun), 32'd0);

    // Valid offered on the load edge of an empty frame: underrun, sent next frame.
    waitUntil(6 * FRAME_CLKS - 1);
`ifdef I2S_TX_HOLD_LAST_EN
    sb.push_back(dPair(2));
`else
    sb.push_back(mkPair('0, '0));
`endif
    x = mkPair(24'h96C3A5, 24'h0F1E2D);
    sb.push_back(x);
    bus.sample_valid = 1'b1;
    bus.left_in      = x.left;
    bus.right_in     = x.right;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checkOutput("simul_underrun", 32'(underrun), 32'd1);
    checkOutput("simul_ready", 32'(bus.sample_ready), 32'd0);

    // Latency: MSB on SD at the slot-1 rise, 3*HALF_DIV after the load.
    waitUntil(7 * FRAME_CLKS);
    checkOutput("load7_underrun", 32'(underrun), 32'd0);
    waitUntil(7 * FRAME_CLKS + 3 * HD - 1);
    checkOutput("sd_slot0", 32'(SD), 32'd0);
    waitUntil(7 * FRAME_CLKS + 3 * HD);
    checkOutput("sck_slot1_rise", 32'(SCK), 32'd1);
    checkOutput("sd_msb_latency", 32'(SD), 32'(x.left[DW-1]));

    // Reset mid-frame with a sample held.
    y = mkPair(24'h3C5A7E, 24'hE1D2C3);
    applyStimulus(y, 2000);
    checkOutput("held_ready", 32'(bus.sample_ready), 32'd0);
    waitUntil(7 * FRAME_CLKS + 40 * 2 * HD + 2);
    checkOutput("ws_slot40", 32'(WS), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_sck", 32'(SCK), 32'd0);
    checkOutput("midrst_ws", 32'(WS), 32'd0);
    checkOutput("midrst_sd", 32'(SD), 32'd0);
    checkOutput("midrst_underrun", 32'(underrun), 32'd0);
    checkOutput("midrst_ready", 32'(bus.sample_ready), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    sb.push_back(mkPair('0, '0));
    sb.push_back(mkPair('0, '0));
    reset = 1'b0;
    waitUntil(FRAME_CLKS - 1);
    checkOutput("post_rst_no_underrun", 32'(underrun), 32'd0);
    waitUntil(FRAME_CLKS);
    checkOutput("post_rst_underrun", 32'(underrun), 32'd1);
    waitUntil(2 * FRAME_CLKS + 2);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
